// File: rtl/bpred_gshare_ras.sv
// Branch predictor: gshare direction table with speculative global history and repair,
// a circular return-address stack, a reset-time table sweep, and resolve statistics.
module bpred_gshare_ras #(
    parameter int HIST_BITS     = 14,
    parameter int BHT_ADDR_BITS = 16,
    parameter int RAS_DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              q_pc,
    input  logic                     q_is_br,
    input  logic                     q_is_call,
    input  logic                     q_is_ret,
    input  logic                     q_stall,
    output logic                     q_taken,
    output logic [BHT_ADDR_BITS-1:0] q_index,
    output logic [HIST_BITS-1:0]     q_hist,
    output logic [31:0]              q_ras_addr,
    output logic                     q_ras_valid,
    input  logic                     u_valid,
    input  logic [BHT_ADDR_BITS-1:0] u_index,
    input  logic [HIST_BITS-1:0]     u_hist,
    input  logic                     u_taken,
    input  logic                     u_mispredict,
    output logic                     ready,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispredicts
);

    // state | meaning
    // INIT  | sweeping every pattern-table entry to weakly-not-taken; lookups/updates ignored
    // RUN   | normal prediction, update, history repair and RAS operation

    localparam int BHT_ENTRIES = 1 << BHT_ADDR_BITS;
    localparam int RAS_PTR_W   = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W   = $clog2(RAS_DEPTH + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                   state_q, state_d;
    logic [BHT_ADDR_BITS-1:0] ptr_q;
    logic [HIST_BITS-1:0]     gh_q;
    logic [1:0]               bht [BHT_ENTRIES];
    logic [31:0]              ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0]     top_q, top_inc, top_dec;
    logic [RAS_CNT_W-1:0]     cnt_q;
    logic                     in_run, ras_push, ras_pop;
    logic [31:0]              ret_addr;
    logic [1:0]               ctr_next;
    logic                     unused_hist_lsb;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (ptr_q == '1) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    assign in_run = (state_q == S_RUN);
    assign ready  = in_run;

    always_ff @(posedge clk) begin
        if (!resetn)              ptr_q <= '0;
        else if (state_q == S_INIT) ptr_q <= ptr_q + BHT_ADDR_BITS'(1);
    end

    // Lookup is purely combinational; a same-cycle update lands only at the edge (no bypass).
    assign q_index  = q_pc[BHT_ADDR_BITS+1:2] ^ BHT_ADDR_BITS'(gh_q);
    assign q_taken  = in_run & bht[q_index][1];
    assign q_hist   = gh_q;
    assign ctr_next = sat_step(bht[u_index], u_taken);

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state_q == S_INIT)   bht[ptr_q]   <= 2'b01;
            else if (u_valid)        bht[u_index] <= ctr_next;
        end
    end

    // Repair wins over a same-cycle speculative shift.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            gh_q <= '0;
        end else if (in_run) begin
            if (u_valid && u_mispredict)  gh_q <= {u_taken, u_hist[HIST_BITS-1:1]};
            else if (q_is_br && !q_stall) gh_q <= {q_taken, gh_q[HIST_BITS-1:1]};
        end
    end

    assign unused_hist_lsb = u_hist[0];

    assign ras_push = in_run && !q_stall && q_is_call;
    assign ras_pop  = in_run && !q_stall && q_is_ret;
    assign ret_addr = q_pc + 32'd4;
    assign top_inc  = top_q + RAS_PTR_W'(1);
    assign top_dec  = top_q - RAS_PTR_W'(1);

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (ras_push && ras_pop) ras[top_q]   <= ret_addr;
            else if (ras_push)       ras[top_inc] <= ret_addr;
        end
    end

    // Overflow keeps the count saturated while the pointer wraps onto the oldest entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            top_q <= '0;
            cnt_q <= '0;
        end else if (ras_push && !ras_pop) begin
            top_q <= top_inc;
            if (cnt_q != RAS_CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + RAS_CNT_W'(1);
        end else if (ras_pop && !ras_push && cnt_q != '0) begin
            top_q <= top_dec;
            cnt_q <= cnt_q - RAS_CNT_W'(1);
        end
    end

    assign q_ras_addr  = ras[top_q];
    assign q_ras_valid = in_run && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (in_run && u_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (u_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_bpred_gshare_ras.sv
// Self-checking bench for bpred_gshare_ras with a 16-entry table, 4-bit history and 4-deep RAS.
module tb_bpred_gshare_ras;

    localparam int HB = 4;
    localparam int AB = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [31:0]   q_pc;
    logic          q_is_br, q_is_call, q_is_ret, q_stall;
    logic          q_taken;
    logic [AB-1:0] q_index;
    logic [HB-1:0] q_hist;
    logic [31:0]   q_ras_addr;
    logic          q_ras_valid;
    logic          u_valid;
    logic [AB-1:0] u_index;
    logic [HB-1:0] u_hist;
    logic          u_taken, u_mispredict;
    logic          ready;
    logic [31:0]   stat_branches, stat_mispredicts;

    bpred_gshare_ras #(.HIST_BITS(HB), .BHT_ADDR_BITS(AB), .RAS_DEPTH(RD)) dut (
        .clk(clk), .resetn(resetn),
        .q_pc(q_pc), .q_is_br(q_is_br), .q_is_call(q_is_call), .q_is_ret(q_is_ret),
        .q_stall(q_stall), .q_taken(q_taken), .q_index(q_index), .q_hist(q_hist),
        .q_ras_addr(q_ras_addr), .q_ras_valid(q_ras_valid),
        .u_valid(u_valid), .u_index(u_index), .u_hist(u_hist), .u_taken(u_taken),
        .u_mispredict(u_mispredict), .ready(ready),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef enum int {K_TAKEN, K_INDEX, K_HIST, K_RADDR, K_RVALID, K_READY, K_SBR, K_SMP} kind_t;
    typedef struct { kind_t kind; logic [31:0] val; } exp_t;
    typedef struct {
        logic [31:0]   pc;
        logic          uv;
        logic          ut;
        logic [AB-1:0] ui;
        logic [AB-1:0] exp_idx;
        logic          exp_before;
        logic          exp_after;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [31:0] actual(kind_t k);
        case (k)
            K_TAKEN:  return {31'd0, q_taken};
            K_INDEX:  return {28'd0, q_index};
            K_HIST:   return {28'd0, q_hist};
            K_RADDR:  return q_ras_addr;
            K_RVALID: return {31'd0, q_ras_valid};
            K_READY:  return {31'd0, ready};
            K_SBR:    return stat_branches;
            default:  return stat_mispredicts;
        endcase
    endfunction

    task automatic expect_val(kind_t k, logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic check_sb(string name);
        exp_t e;
        logic [31:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = actual(e.kind);
            n_checks++;
            if (a === e.val) n_pass++;
            else $display("FAIL %s %s: got %0h expected %0h", name, e.kind.name(), a, e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        q_pc = '0; q_is_br = 0; q_is_call = 0; q_is_ret = 0; q_stall = 0;
        u_valid = 0; u_index = '0; u_hist = '0; u_taken = 0; u_mispredict = 0;
    endtask

    task automatic count_init(string name);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 15) begin expect_val(K_READY, 0); check_sb({name, "_c15"}); end
            if (i == 16) begin expect_val(K_READY, 1); check_sb({name, "_c16"}); end
        end
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h0000_0000, 0, 0, 4'd0, 4'h0, 0, 0};
        vecs[1]  = '{32'h1234_5678, 0, 0, 4'd0, 4'hE, 0, 0};
        vecs[2]  = '{32'hFFFF_FFFC, 0, 0, 4'd0, 4'hF, 0, 0};
        vecs[3]  = '{32'h0000_0014, 1, 1, 4'd5, 4'h5, 0, 1};
        vecs[4]  = '{32'h0000_0014, 1, 1, 4'd5, 4'h5, 1, 1};
        vecs[5]  = '{32'h0000_0014, 1, 1, 4'd5, 4'h5, 1, 1};
        vecs[6]  = '{32'h0000_0014, 1, 0, 4'd5, 4'h5, 1, 1};
        vecs[7]  = '{32'h0000_0014, 1, 0, 4'd5, 4'h5, 1, 0};
        vecs[8]  = '{32'h0000_0014, 1, 0, 4'd5, 4'h5, 0, 0};
        vecs[9]  = '{32'h0000_0014, 1, 0, 4'd5, 4'h5, 0, 0};
        vecs[10] = '{32'h0000_0018, 0, 0, 4'd0, 4'h6, 0, 0};

        clear_in();
        resetn = 0;
        @(negedge clk);
        cyc(); cyc(); cyc();
        expect_val(K_READY, 0); expect_val(K_TAKEN, 0); expect_val(K_RVALID, 0);
        expect_val(K_HIST, 0);  expect_val(K_SBR, 0);   expect_val(K_SMP, 0);
        check_sb("reset");

        // Abort the sweep at ptr = 7; it must restart from zero.
        resetn = 1;
        for (int i = 0; i < 7; i++) cyc();
        resetn = 0;
        cyc();
        expect_val(K_READY, 0);
        check_sb("midinit_reset");
        resetn = 1;
        count_init("init");

        foreach (vecs[i]) begin
            q_pc = vecs[i].pc; u_valid = vecs[i].uv; u_taken = vecs[i].ut; u_index = vecs[i].ui;
            #1;
            expect_val(K_INDEX, {28'd0, vecs[i].exp_idx});
            expect_val(K_HIST, 0);
            expect_val(K_TAKEN, {31'd0, vecs[i].exp_before});
            check_sb($sformatf("vec%0d_before", i));
            cyc();
            u_valid = 0;
            #1;
            expect_val(K_TAKEN, {31'd0, vecs[i].exp_after});
            check_sb($sformatf("vec%0d_after", i));
        end
        expect_val(K_SBR, 7); expect_val(K_SMP, 0);
        check_sb("stats_after_updates");

        // Establish GH = 1010 through a repair (also makes counter 0 weakly taken).
        clear_in();
        u_valid = 1; u_mispredict = 1; u_taken = 1; u_index = 4'd0; u_hist = 4'b0100;
        cyc();
        clear_in();
        expect_val(K_HIST, 4'b1010); expect_val(K_SMP, 1); expect_val(K_SBR, 8);
        check_sb("gh_setup");

        // Taken speculative shift collides with a mispredict repair: repair wins.
        q_pc = 32'h28; q_is_br = 1;
        u_valid = 1; u_mispredict = 1; u_taken = 0; u_index = 4'd7; u_hist = 4'b0110;
        #1;
        expect_val(K_INDEX, 0); expect_val(K_TAKEN, 1); expect_val(K_HIST, 4'b1010);
        check_sb("repair_lookup");
        cyc();
        clear_in();
        expect_val(K_HIST, 4'b0011); expect_val(K_SMP, 2); expect_val(K_SBR, 9);
        check_sb("repair_result");

        q_pc = 32'h0C; q_is_br = 1;
        #1;
        expect_val(K_INDEX, 0); expect_val(K_TAKEN, 1);
        check_sb("shift_taken_lookup");
        cyc();
        expect_val(K_HIST, 4'b1001);
        check_sb("shift_taken");

        q_pc = 32'h3C;
        #1;
        expect_val(K_INDEX, 4'h6); expect_val(K_TAKEN, 0);
        check_sb("shift_nt_lookup");
        cyc();
        expect_val(K_HIST, 4'b0100);
        check_sb("shift_nt");

        q_is_call = 1; q_stall = 1;
        cyc();
        clear_in();
        expect_val(K_HIST, 4'b0100); expect_val(K_RVALID, 0);
        check_sb("stall");

        for (int i = 1; i <= 5; i++) begin
            q_pc = 32'h100 * i; q_is_call = 1;
            cyc();
            expect_val(K_RVALID, 1); expect_val(K_RADDR, 32'h100 * i + 32'h4);
            check_sb($sformatf("push%0d", i));
        end
        clear_in();

        for (int i = 5; i >= 2; i--) begin
            q_is_ret = 1;
            #1;
            expect_val(K_RVALID, 1); expect_val(K_RADDR, 32'h100 * i + 32'h4);
            check_sb($sformatf("pop_%0h", 32'h100 * i + 32'h4));
            cyc();
        end
        clear_in();
        expect_val(K_RVALID, 0);
        check_sb("ras_empty");

        q_is_ret = 1;
        cyc();
        clear_in();
        expect_val(K_RVALID, 0);
        check_sb("pop_on_empty");

        q_pc = 32'h40; q_is_call = 1;
        cyc();
        expect_val(K_RADDR, 32'h44); expect_val(K_RVALID, 1);
        check_sb("push_40");
        q_pc = 32'h80; q_is_call = 1; q_is_ret = 1;
        cyc();
        clear_in();
        expect_val(K_RADDR, 32'h84); expect_val(K_RVALID, 1);
        check_sb("push_pop_same_cycle");
        q_is_ret = 1;
        cyc();
        clear_in();
        expect_val(K_RVALID, 0);
        check_sb("count_unchanged");

        expect_val(K_SBR, 9); expect_val(K_SMP, 2);
        check_sb("final_stats");

        resetn = 0;
        cyc();
        expect_val(K_READY, 0); expect_val(K_SBR, 0); expect_val(K_SMP, 0);
        expect_val(K_HIST, 0);  expect_val(K_RVALID, 0); expect_val(K_TAKEN, 0);
        check_sb("run_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bpred_gshare_ras.md
# bpred_gshare_ras

Parametrised branch-prediction unit for the torv32 pipeline, replacing the inline gshare table in the core. It serves fetch/decode lookups with a gshare direction prediction and a return-address-stack (RAS) target. It takes resolution updates from execute and repairs speculative global history on mispredict. A reset sweep initialises the pattern table to weakly-not-taken, and two statistics counters are exported.

## Interface
- HIST_BITS, 14, global history length; must be ≤ BHT_ADDR_BITS.
- BHT_ADDR_BITS, 16, log2 of the pattern-table entry count; entries are 2-bit saturating counters.
- RAS_DEPTH, 8, RAS entry count; must be a power of 2, ≥2.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- q_pc  in  32  PC of the instruction in decode.
- q_is_br  in  1  decode holds a conditional branch (valid, not flushed).
- q_is_call  in  1  decode holds a JAL/JALR with rd ∈ {x1,x5}.
- q_is_ret  in  1  decode holds a JALR with rs1 ∈ {x1,x5}, rd = x0.
- q_stall  in  1  decode stalled; lookup causes no state change.
- q_taken  out  1  predicted direction (counter MSB).
- q_index  out  BHT_ADDR_BITS  table index; core carries it to execute.
- q_hist  out  HIST_BITS  speculative history snapshot; core carries it to execute.
- q_ras_addr  out  32  RAS top-of-stack.
- q_ras_valid  out  1  RAS non-empty.
- u_valid  in  1  branch resolved in execute this cycle.
- u_index  in  BHT_ADDR_BITS  index captured at lookup.
- u_hist  in  HIST_BITS  history captured at lookup.
- u_taken  in  1  actual outcome.
- u_mispredict  in  1  actual ≠ predicted.
- ready  out  1  init sweep complete.
- stat_branches  out  32  resolved-branch count.
- stat_mispredicts  out  32  mispredict count.

## Operation
- FSM states: INIT, RUN. Reset enters INIT with sweep pointer 0.
- INIT: write 2'b01 to BHT[ptr] each cycle and increment ptr. Leave INIT on the cycle ptr = 2^BHT_ADDR_BITS−1 is written. During INIT, q_taken = 0, q_ras_valid = 0, and all lookups and updates are ignored.
- Index: q_index = q_pc[BHT_ADDR_BITS+1:2] XOR zero-extended GH. q_taken = BHT[q_index][1]. q_hist = GH.
- Speculative history: in RUN, when q_is_br & !q_stall, GH ← {q_taken, GH[HIST_BITS−1:1]}.
- Update: in RUN, when u_valid, BHT[u_index] ← saturating inc (u_taken = 1) or dec (u_taken = 0). Counters clamp at 00 and 11. stat_branches increments.
- Repair: when u_valid & u_mispredict, GH ← {u_taken, u_hist[HIST_BITS−1:1]}. Repair has priority over a same-cycle speculative shift, and the lookup's shift is discarded. stat_mispredicts increments.
- RAS: circular buffer with top pointer and count (0..RAS_DEPTH). Active only in RUN and when !q_stall.
  - Push (q_is_call only): entry[top+1] ← q_pc+4, top++, count saturates at RAS_DEPTH. Overflow overwrites the oldest entry.
  - Pop (q_is_ret only): top−−, count−−. Pop when count = 0 leaves everything unchanged.
  - Push and pop together: entry[top] ← q_pc+4, top and count unchanged.
  - No RAS repair on mispredict.
- Statistics counters wrap mod 2^32 and do not saturate.

## Timing
- Reset values: ready = 0, GH = 0, RAS count = 0, top = 0, stat counters = 0, q_taken = 0, q_ras_valid = 0.
- Lookup outputs are combinational from q_pc and current state, with zero cycles of latency.
- All state writes occur at posedge clk. An update and a lookup to the same index in the same cycle: the lookup sees the old counter (no bypass). The new value is visible the next cycle.
- A GH change, from either shift or repair, is visible to the lookup on the next cycle.
- ready rises on the cycle after the final INIT write: 2^BHT_ADDR_BITS cycles after the first clock with resetn = 1.
- resetn low in any state, including mid-INIT, restarts INIT from ptr 0 and clears GH, RAS, and the stat counters on the next edge.
- The u_* inputs must not be asserted while ready = 0; they are ignored if they are.

## Test plan
- BHT_ADDR_BITS = 4: release reset → ready = 1 exactly 16 cycles later; any q_pc → q_taken = 0, counter reads 01.
- Three u_valid taken updates to index 5 → counter 01→10→11→11, q_taken = 1 from the cycle after the first update. Four not-taken updates → 00, clamped.
- HIST_BITS = 4, GH = 4'b1010: lookup shift with q_taken = 1 in the same cycle as mispredict with u_hist = 4'b0110, u_taken = 0 → GH = 4'b0011; stat_mispredicts = 1.
- RAS_DEPTH = 4: push PCs 0x100, 0x200, 0x300, 0x400, 0x500 (five pushes) → count = 4. Pops return 0x504, 0x404, 0x304, 0x204, then q_ras_valid = 0 and a further pop leaves the state unchanged.
- Simultaneous push (q_pc = 0x80) and pop with top = 0x44 → q_ras_addr = 0x84 next cycle, count unchanged.
- resetn low mid-INIT (ptr = 7) → ready stays 0, sweep restarts, ready after a full 2^BHT_ADDR_BITS cycles. A q_stall = 1 lookup with q_is_call = 1 and q_is_br = 1 → GH and RAS unchanged.
